// File: rtl/crc_piso_serializer_if.sv
// Word-in / bit-out bus of crc_piso_serializer.
// master = packet source and line-side consumer; slave = the serializer.
interface crc_piso_serializer_if #(
  parameter int DATA_W = 8,
  parameter int CRC_W  = 16
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic              en;
  logic              abort;
  logic              out_bit;
  logic              out_valid;
  logic              out_stuff;
  logic              eop;
  logic              underrun;
  logic [CRC_W-1:0]  crc_result;

  modport master (
    output in_data, in_valid, in_last, en, abort,
    input  in_ready, out_bit, out_valid, out_stuff, eop, underrun, crc_result
  );

  modport slave (
    input  in_data, in_valid, in_last, en, abort,
    output in_ready, out_bit, out_valid, out_stuff, eop, underrun, crc_result
  );
endinterface

// File: rtl/crc_piso_serializer.sv
// Packet serializer: DATA_W-bit words out LSB-first, then the complemented CRC MSB-first.
// Define CRC_SER_BIT_STUFF_EN to insert a stuffed 0 after every six consecutive 1s.
module crc_piso_serializer #(
  parameter int               DATA_W = 8,
  parameter int               CRC_W  = 16,
  parameter logic [CRC_W-1:0] POLY   = 16'h8005
) (
  input  logic                 clk,
  input  logic                 rst_b,
  crc_piso_serializer_if.slave bus
);
  localparam int CNT_MAX = (DATA_W > CRC_W) ? DATA_W : CRC_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(CRC_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CRC_W-1:0]    crc_q, crc_d;
  logic [CRC_W-1:0]    crc_res_q, crc_res_d;
  logic                last_q, last_d;
  logic                eop_q, eop_d;
  logic                underrun_q, underrun_d;
  logic                ready_c;
  logic                crc_bit;
  logic                cur_bit;
  logic                bit_take;
  logic                stuff_pend;
  logic                stuff_next;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
    logic fb;
    fb = b ^ c[CRC_W-1];
    return {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  endfunction

  always_comb begin
    crc_bit = 1'b0;
    for (int i = 0; i < CRC_W; i++) begin
      if (cnt_q == CNT_W'(CRC_W - 1 - i)) crc_bit = ~crc_q[i];
    end
  end

  assign cur_bit  = (state_q == S_DATA) ? shreg_q[0] :
                    (state_q == S_CRC)  ? crc_bit    : 1'b0;
  assign bit_take = (state_q != S_IDLE) && bus.en && !stuff_pend;

`ifdef CRC_SER_BIT_STUFF_EN
  localparam logic [CNT_W-1:0] CRC_DONE = CNT_W'(CRC_W);
  logic [2:0] ones_q;

  assign stuff_pend = (ones_q == 3'd6) && (state_q != S_IDLE);
  assign stuff_next = cur_bit && (ones_q == 3'd5);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ones_q <= '0;
    end else if (state_q == S_IDLE || (bus.en && stuff_pend)) begin
      ones_q <= '0;
    end else if (bit_take) begin
      ones_q <= cur_bit ? ones_q + 3'd1 : 3'd0;
    end
  end
`else
  assign stuff_pend = 1'b0;
  assign stuff_next = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    crc_res_d  = crc_res_q;
    last_d     = last_q;
    eop_d      = 1'b0;
    underrun_d = 1'b0;
    ready_c    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ready_c = 1'b1;
        if (bus.in_valid) begin
          shreg_d = bus.in_data;
          last_d  = bus.in_last;
          cnt_d   = '0;
          crc_d   = '1;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        // Next word is taken on the strobe that consumes the current word's final bit.
        ready_c = (cnt_q == DATA_LAST) && !last_q && bus.en && !stuff_pend;
        if (bit_take) begin
          crc_d   = crc_step(crc_q, cur_bit);
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == DATA_LAST) begin
            cnt_d = '0;
            if (last_q) begin
              state_d = S_CRC;
            end else if (bus.in_valid) begin
              shreg_d = bus.in_data;
              last_d  = bus.in_last;
            end else begin
              state_d    = S_IDLE;
              underrun_d = 1'b1;
            end
          end
        end
      end
      S_CRC: begin
        if (bit_take) begin
          // A stuff owed after the last CRC bit parks cnt one past the end until sent.
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CRC_LAST && !stuff_next) begin
            state_d   = S_IDLE;
            eop_d     = 1'b1;
            crc_res_d = ~crc_q;
          end
        end
`ifdef CRC_SER_BIT_STUFF_EN
        else if (bus.en && cnt_q == CRC_DONE) begin
          state_d   = S_IDLE;
          eop_d     = 1'b1;
          crc_res_d = ~crc_q;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.abort) begin
      state_d    = S_IDLE;
      ready_c    = 1'b0;
      eop_d      = 1'b0;
      underrun_d = 1'b0;
      crc_res_d  = crc_res_q;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      crc_q      <= '0;
      crc_res_q  <= '0;
      last_q     <= 1'b0;
      eop_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      crc_res_q  <= crc_res_d;
      last_q     <= last_d;
      eop_q      <= eop_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus.in_ready   = ready_c;
  assign bus.out_bit    = stuff_pend ? 1'b0 : cur_bit;
  assign bus.out_valid  = (state_q != S_IDLE);
  assign bus.out_stuff  = stuff_pend;
  assign bus.eop        = eop_q;
  assign bus.underrun   = underrun_q;
  assign bus.crc_result = crc_res_q;
endmodule
